serializador: RTL and testbench

Parallel-to-serial transmitter: the sending end of the serial bit link whose receiving end is `deserializador`. Accepts bytes from the parallel side through a valid/ready handshake and buffers them in a small FIFO. Shifts each byte out MSB-first as 8 consecutive `write_out` strobes. Paces bytes by watching the receiver's `status_out` so no bit is sent while the receiver holds a completed word.

---
 rtl/serializador_pkg.sv | 14 +
 rtl/serializador_if.sv | 22 ++
 rtl/serializador_fila_bytes.sv | 61 ++++++
 rtl/serializador.sv | 97 +++++++++
 tb/tb_serializador.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serializador_pkg.sv
// serializador shared types
// tx FSM states and word width
package serial_pkg;

  localparam int WORD_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_HI,
    WAIT_LO
  } tx_state_t;

endpackage

// File: rtl/serializador_if.sv
// serializador parallel-side bus
// byte handshake: producer drives, FIFO answers
interface serializador_if;
  import serial_pkg::*;

  logic [WORD_W-1:0] data_in;
  logic              data_valid;
  logic              ready_out;

  modport master (
    output data_in,
    output data_valid,
    input  ready_out
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output ready_out
  );

endinterface

// File: rtl/serializador_fila_bytes.sv
// fila_bytes: synchronous byte FIFO
// power-of-two depth, wrapping pointers
module fila_bytes #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // a full FIFO refuses a push even if it pops this cycle
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // storage write; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serializador.sv
// serializador: byte FIFO to MSB-first bit stream
// paced by the receiver's full/ack status
module serializador
  import serial_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic           clk_100KHz,
  input  logic           reset,
  serializador_if.slave  bus,
  input  logic           status_in,
  output logic           data_out,
  output logic           write_out,
  output logic           busy
);

  tx_state_t         state;
  logic [WORD_W-1:0] shreg;
  logic [2:0]        bitcnt;
  logic [WORD_W-1:0] head;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign bus.ready_out = (count != CW'(DEPTH));
  assign push          = bus.data_valid && !full;
  assign pop           = (state == IDLE) && !empty;
  assign busy          = (state != IDLE) || !empty;

  fila_bytes #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_fila (
    .clk   (clk_100KHz),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.data_in),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // tx FSM: load, shift 8 strobes, then wait for receiver ack
  always_ff @(posedge clk_100KHz) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      data_out  <= 1'b0;
      write_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          write_out <= 1'b0;
          data_out  <= 1'b0;
          if (!empty) begin
            shreg  <= head;
            bitcnt <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          write_out <= 1'b1;
          data_out  <= shreg[WORD_W-1];
          shreg     <= {shreg[WORD_W-2:0], 1'b0};
          bitcnt    <= bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            state <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          write_out <= 1'b0;
          data_out  <= 1'b0;
          if (status_in) begin
            state <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          write_out <= 1'b0;
          data_out  <= 1'b0;
          if (!status_in) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializador.sv
// tb_serializador: directed bench
// behavioural receiver provides status ack
`timescale 1ns/1ps
module tb_serializador;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic status_in;
  logic data_out;
  logic write_out;
  logic busy;

  serializador_if bus ();

  serializador #(.DEPTH(DEPTH)) dut (
    .clk_100KHz (clk),
    .reset      (reset),
    .bus        (bus),
    .status_in  (status_in),
    .data_out   (data_out),
    .write_out  (write_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       status_force = 1'b0;
  logic       force_val = 1'b0;
  logic [7:0] rx_sr = '0;
  logic [2:0] rx_bits = '0;
  logic       rx_full = 1'b0;
  logic [2:0] rx_hold = '0;
  logic [7:0] rx_log [0:63];
  int         rx_n = 0;
  logic       viol = 1'b0;
  logic       wo_nobusy = 1'b0;

  assign status_in = status_force ? force_val : rx_full;

  // receiver model: 8 strobes complete a word, hold full 4 cycles
  always @(posedge clk) begin
    if (reset) begin
      rx_bits <= '0;
      rx_full <= 1'b0;
      rx_hold <= '0;
    end else begin
      if (rx_full) begin
        if (rx_hold == 0) rx_full <= 1'b0;
        else rx_hold <= rx_hold - 3'd1;
      end
      if (write_out) begin
        rx_sr <= {rx_sr[6:0], data_out};
        if (rx_bits == 3'd7) begin
          rx_log[rx_n] <= {rx_sr[6:0], data_out};
          rx_n    <= rx_n + 1;
          rx_bits <= '0;
          rx_full <= 1'b1;
          rx_hold <= 3'd3;
        end else begin
          rx_bits <= rx_bits + 3'd1;
        end
      end
    end
  end

  // protocol monitors
  always @(posedge clk) begin
    if (!status_force && write_out && rx_full) viol <= 1'b1;
    if (write_out && !busy) wo_nobusy <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, output logic acc);
    @(negedge clk);
    bus.data_in    = b;
    bus.data_valid = 1'b1;
    acc            = bus.ready_out;
    @(posedge clk);
    #1 bus.data_valid = 1'b0;
  endtask

  task automatic push_wait(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.ready_out && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("push_wait", 32'(t < 500), 1);
    bus.data_in    = b;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1 bus.data_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int t;
    t = 0;
    while (rx_n < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("rx_wait", 32'(rx_n >= n), 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_wait", 32'(busy), 0);
  endtask

  initial begin
    logic [7:0] b;
    logic       acc;
    logic [5:0] accv;
    int         base;
    int         t;

    reset          = 1'b1;
    bus.data_in    = '0;
    bus.data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_write_out", 32'(write_out), 0);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(bus.ready_out), 1);
    @(negedge clk);
    reset = 1'b0;

    // single byte A5, timing relative to push edge E0
    b = 8'hA5;
    push_byte(b, acc);
    chk("a5_acc", 32'(acc), 1);
    chk("a5_busy", 32'(busy), 1);
    @(posedge clk);
    #1 chk("a5_e1_wo", 32'(write_out), 0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1 chk("a5_bit", {30'd0, write_out, data_out}, {30'd0, 1'b1, b[7-k]});
    end
    @(posedge clk);
    #1 chk("a5_e10_wo", 32'(write_out), 0);
    wait_rx(1);
    chk("a5_rx", 32'(rx_log[0]), 32'h A5);
    wait_idle();

    // pacing of back-to-back bytes
    push_byte(8'h3C, acc);
    push_byte(8'hC3, acc);
    wait_rx(3);
    chk("pace_rx0", 32'(rx_log[1]), 32'h3C);
    chk("pace_rx1", 32'(rx_log[2]), 32'hC3);
    chk("pace_viol", 32'(viol), 0);
    wait_idle();

    // FIFO full with receiver held full
    status_force = 1'b1;
    force_val    = 1'b1;
    base         = rx_n;
    for (int i = 0; i < DEPTH + 2; i++) begin
      b = 8'h10 + 8'(i);
      push_byte(b, acc);
      accv[i] = acc;
    end
    chk("full_accepted", 32'(accv), 32'b011111);
    chk("full_ready", 32'(bus.ready_out), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("full_hold_wo", 32'(write_out), 0);
    chk("full_hold_rdy", 32'(bus.ready_out), 0);

    // release: push offered on the very pop edge is refused
    @(negedge clk);
    force_val = 1'b0;
    @(negedge clk);
    bus.data_in    = 8'hEE;
    bus.data_valid = 1'b1;
    chk("pop_rdy_before", 32'(bus.ready_out), 0);
    @(posedge clk);
    #1 bus.data_valid = 1'b0;
    chk("pop_count", 32'(dut.u_fila.count), 3);
    chk("pop_rdy_after", 32'(bus.ready_out), 1);
    status_force = 1'b0;
    wait_rx(base + DEPTH + 1);
    for (int i = 0; i < DEPTH + 1; i++) begin
      chk("full_order", 32'(rx_log[base+i]), 32'h10 + 32'(i));
    end
    wait_idle();
    chk("full_total", 32'(rx_n), 32'(base + DEPTH + 1));

    // pointer wrap with continuous stream
    base = rx_n;
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      push_wait(8'(i));
    end
    wait_rx(base + 2 * DEPTH + 1);
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      chk("wrap_order", 32'(rx_log[base+i]), 32'(i));
    end
    wait_idle();
    chk("wrap_wo_nobusy", 32'(wo_nobusy), 0);
    chk("wrap_wo_low", 32'(write_out), 0);

    // reset during the 4th strobe of F0, with 0F queued
    push_byte(8'hF0, acc);
    push_byte(8'h0F, acc);
    t = 0;
    @(negedge clk);
    while (!write_out && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rst_strobe_seen", 32'(write_out), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_wo", 32'(write_out), 0);
    chk("midrst_ready", 32'(bus.ready_out), 1);
    chk("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    base  = rx_n;
    push_byte(8'h81, acc);
    wait_rx(base + 1);
    chk("midrst_rx", 32'(rx_log[base]), 32'h81);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("midrst_total", 32'(rx_n), 32'(base + 1));
    chk("final_viol", 32'(viol), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
